// File: rtl/oam_dma_ctrl.sv
// -----------------------------------------------------------------------------
// oam_dma_ctrl
//
// Sprite-attribute (OAM) DMA engine for a 6502-style bus. A CPU write to
// TRIGGER_ADDR latches a source page. The CPU is then halted while 256 bytes
// are copied from {page, 8'h00}..{page, 8'hFF} to OAM_DATA_ADDR. Each byte
// takes one READ cycle followed by one WRITE cycle.
//
// The bus alternates GET (parity 0) and PUT (parity 1) cycles, and every READ
// must fall on a GET cycle. After the single HALT cycle, an ALIGN cycle is
// inserted only when the next cycle would otherwise be a PUT. The CPU is
// therefore stopped for 513 or 514 cycles in total.
//
// Ports
//   CLK           in   CPU clock; one CLK is one bus cycle
//   RESET         in   synchronous, active-high reset
//   CPU_ADDR      in   [15:0] CPU address, snooped for TRIGGER_ADDR
//   CPU_DATA_OUT  in   [7:0]  CPU write data (page number on trigger)
//   CPU_RW_n      in   CPU direction: 1 = read, 0 = write
//   DATA_BUS      in   [7:0]  system read data, sampled at the end of READ
//   CPU_ENABLE    out  CPU clock enable; 1 only in IDLE
//   DMA_ACTIVE    out  1 while the DMA drives the bus (READ/WRITE)
//   DMA_ADDR      out  [15:0] DMA bus address, 0 when not active
//   DMA_RW_n      out  DMA direction: 1 = read, 0 = write
//   DMA_DATA_OUT  out  [7:0]  contents of the read-data latch
//   DMA_DONE      out  high only during the final WRITE cycle
// -----------------------------------------------------------------------------
module oam_dma_ctrl #(
  parameter logic [15:0] TRIGGER_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] CPU_ADDR,
  input  logic [7:0]  CPU_DATA_OUT,
  input  logic        CPU_RW_n,
  input  logic [7:0]  DATA_BUS,
  output logic        CPU_ENABLE,
  output logic        DMA_ACTIVE,
  output logic [15:0] DMA_ADDR,
  output logic        DMA_RW_n,
  output logic [7:0]  DMA_DATA_OUT,
  output logic        DMA_DONE
);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic       parity_q;   // 0 = GET, 1 = PUT for the current cycle
  logic [7:0] page_q;
  logic [7:0] index_q;
  logic [7:0] latch_q;
  logic       trigger;
  logic       last_byte;

  // CPU_ENABLE is high exactly in IDLE, so the IDLE test stands in for it.
  // This keeps the trigger independent of the output decode below.
  assign trigger = (state_q == IDLE) && !CPU_RW_n && (CPU_ADDR == TRIGGER_ADDR);

  assign last_byte = (index_q == 8'hFF);

  // The data output always shows the latch, whether or not the DMA is active.
  assign DMA_DATA_OUT = latch_q;

  // NOTE: every flop is updated with <= so that all registers sample the
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      parity_q <= 1'b0;
      page_q   <= 8'h00;
      index_q  <= 8'h00;
      latch_q  <= 8'h00;
    end else begin
      parity_q <= ~parity_q;
      if (trigger) begin
        page_q  <= CPU_DATA_OUT;
        index_q <= 8'h00;
      end
      if (state_q == READ) begin
        latch_q <= DATA_BUS;
      end
      if (state_q == WRITE) begin
        index_q <= index_q + 8'd1;
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    CPU_ENABLE = 1'b0;
    DMA_ACTIVE = 1'b0;
    DMA_ADDR   = 16'h0000;
    DMA_RW_n   = 1'b1;
    DMA_DONE   = 1'b0;

    case (state_q)
      IDLE: begin
        CPU_ENABLE = 1'b1;
        if (trigger) begin
          state_d = HALT;
        end
      end

      // If this cycle is a PUT, the next one is a GET and reading can start.
      // Otherwise, one ALIGN cycle is spent first.
      HALT: begin
        state_d = parity_q ? READ : ALIGN;
      end

      ALIGN: begin
        state_d = READ;
      end

      READ: begin
        DMA_ACTIVE = 1'b1;
        DMA_ADDR   = {page_q, index_q};
        state_d    = WRITE;
      end

      WRITE: begin
        DMA_ACTIVE = 1'b1;
        DMA_ADDR   = OAM_DATA_ADDR;
        DMA_RW_n   = 1'b0;
        DMA_DONE   = last_byte;
        state_d    = last_byte ? IDLE : READ;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// -----------------------------------------------------------------------------
// tb_oam_dma_ctrl
//
// Directed bench for oam_dma_ctrl. A small bus model answers DMA reads with
// (low address byte ^ salt). Each trigger pushes the expected 256 read
// addresses and 256 write bytes into queues. These are popped and compared as
// the DUT performs the transfer.
//
// The bench tracks bus parity independently and checks the following:
//   - halt length
//   - ALIGN presence
//   - that every READ falls on GET
//   - DMA_DONE
//   - abort on reset
//   - no false triggers
// -----------------------------------------------------------------------------
module tb_oam_dma_ctrl;

  logic        CLK;
  logic        RESET;
  logic [15:0] CPU_ADDR;
  logic [7:0]  CPU_DATA_OUT;
  logic        CPU_RW_n;
  logic [7:0]  DATA_BUS;
  logic        CPU_ENABLE;
  logic        DMA_ACTIVE;
  logic [15:0] DMA_ADDR;
  logic        DMA_RW_n;
  logic [7:0]  DMA_DATA_OUT;
  logic        DMA_DONE;

  int          vectors;
  int          miscompares;
  logic [7:0]  salt;
  logic        cyc_par;   // bench model of GET/PUT parity
  logic [15:0] exp_rd_q[$];
  logic [7:0]  exp_wr_q[$];

  oam_dma_ctrl dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .CPU_ADDR     (CPU_ADDR),
    .CPU_DATA_OUT (CPU_DATA_OUT),
    .CPU_RW_n     (CPU_RW_n),
    .DATA_BUS     (DATA_BUS),
    .CPU_ENABLE   (CPU_ENABLE),
    .DMA_ACTIVE   (DMA_ACTIVE),
    .DMA_ADDR     (DMA_ADDR),
    .DMA_RW_n     (DMA_RW_n),
    .DMA_DATA_OUT (DMA_DATA_OUT),
    .DMA_DONE     (DMA_DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory model: byte at address a is a[7:0] ^ salt.
  assign DATA_BUS = (DMA_ACTIVE && DMA_RW_n) ? (DMA_ADDR[7:0] ^ salt) : 8'hEE;

  always @(posedge CLK) cyc_par <= RESET ? 1'b0 : ~cyc_par;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_idle();
    CPU_ADDR     = 16'h0000;
    CPU_RW_n     = 1'b1;
    CPU_DATA_OUT = 8'h00;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cpu_en"}, CPU_ENABLE, 1);
    check({tag, "_active"}, DMA_ACTIVE, 0);
    check({tag, "_addr"}, DMA_ADDR, 16'h0000);
    check({tag, "_rw"}, DMA_RW_n, 1);
    check({tag, "_done"}, DMA_DONE, 0);
  endtask

  // The caller must be at an IDLE cycle (posedge + 1). The trigger is driven
  // during this cycle, and the task returns at the first IDLE cycle after the
  // transfer. If abort_at is nonzero, RESET is asserted during that WRITE.
  task automatic dma_run(input logic [7:0] page, input logic [7:0] s,
                         input int abort_at, input bit false_trig);
    int         low;
    int         pre;
    int         writes;
    int         dones;
    int         exp_pre;
    bit         started;
    logic [7:0] exp_byte;
    salt = s;
    check("pre_trigger_idle", CPU_ENABLE, 1);
    exp_pre = (cyc_par == 1'b1) ? 2 : 1;
    for (int i = 0; i < 256; i++) begin
      exp_rd_q.push_back({page, 8'(i)});
      exp_wr_q.push_back(8'(i) ^ s);
    end
    CPU_ADDR     = 16'h4014;
    CPU_RW_n     = 1'b0;
    CPU_DATA_OUT = page;
    step();
    low = 0; pre = 0; writes = 0; dones = 0; started = 0;
    while (!CPU_ENABLE && low < 600) begin
      low++;
      if (false_trig) begin
        CPU_ADDR     = 16'h4014;
        CPU_RW_n     = 1'b0;
        CPU_DATA_OUT = page ^ 8'hFF;
      end else begin
        bus_idle();
      end
      if (DMA_ACTIVE) begin
        started = 1;
        if (DMA_RW_n) begin
          if (exp_rd_q.size() == 0) check("rd_q_underflow", DMA_ACTIVE, 0);
          else check("rd_addr", DMA_ADDR, exp_rd_q.pop_front());
          check("rd_on_get", cyc_par, 0);
          check("rd_done_low", DMA_DONE, 0);
        end else begin
          writes++;
          check("wr_addr", DMA_ADDR, 16'h2004);
          if (exp_wr_q.size() == 0) check("wr_q_underflow", DMA_ACTIVE, 0);
          else begin
            exp_byte = exp_wr_q.pop_front();
            check("wr_data", DMA_DATA_OUT, exp_byte);
          end
          check("wr_done", DMA_DONE, (writes == 256));
          if (DMA_DONE) dones++;
        end
      end else begin
        check("halt_addr", DMA_ADDR, 16'h0000);
        check("halt_rw", DMA_RW_n, 1);
        if (started) check("halt_gap", DMA_ACTIVE, 1);
        else pre++;
      end
      if (abort_at != 0 && DMA_ACTIVE && !DMA_RW_n && writes == abort_at) begin
        RESET = 1'b1;
        bus_idle();
        step();
        RESET = 1'b0;
        check("abort_cpu_en", CPU_ENABLE, 1);
        check("abort_active", DMA_ACTIVE, 0);
        check("abort_data", DMA_DATA_OUT, 8'h00);
        check("abort_addr", DMA_ADDR, 16'h0000);
        for (int k = 0; k < 20; k++) begin
          step();
          check("post_abort_active", DMA_ACTIVE, 0);
          check("post_abort_cpu_en", CPU_ENABLE, 1);
        end
        exp_rd_q.delete();
        exp_wr_q.delete();
        return;
      end
      step();
    end
    bus_idle();
    check("halt_len", low, 512 + exp_pre);
    check("pre_len", pre, exp_pre);
    check("done_count", dones, 1);
    check("rd_q_left", exp_rd_q.size(), 0);
    check("wr_q_left", exp_wr_q.size(), 0);
    check("back_cpu_en", CPU_ENABLE, 1);
    check("back_active", DMA_ACTIVE, 0);
    exp_rd_q.delete();
    exp_wr_q.delete();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    salt        = 8'h00;
    RESET       = 1'b1;
    // A trigger is held during reset and must be ignored.
    CPU_ADDR     = 16'h4014;
    CPU_RW_n     = 1'b0;
    CPU_DATA_OUT = 8'h77;
    step();
    step();
    check_idle("reset");
    check("reset_data", DMA_DATA_OUT, 8'h00);
    RESET = 1'b0;
    bus_idle();
    step();
    check_idle("no_trig_in_reset");

    // A CPU read of the trigger address must not start a DMA.
    CPU_ADDR = 16'h4014;
    CPU_RW_n = 1'b1;
    step();
    bus_idle();
    check_idle("cpu_read_4014");
    step();
    check_idle("cpu_read_4014_b");

    // Trigger on parity 0: HALT on PUT, reads follow directly (513 cycles).
    while (cyc_par != 1'b0) step();
    dma_run(8'h02, 8'h11, 0, 0);

    // Trigger on parity 1: HALT on GET, ALIGN inserted (514 cycles). A $4014
    // write is also held for the whole halt; it must not extend the DMA.
    while (cyc_par != 1'b1) step();
    dma_run(8'h03, 8'h5A, 0, 1);

    // Retrigger on the very cycle the CPU resumes, using page $FF.
    dma_run(8'hFF, 8'h33, 0, 0);
    for (int k = 0; k < 5; k++) begin
      check_idle("after_page_ff");
      step();
    end

    // Reset at the 100th WRITE aborts the transfer; a new trigger then works.
    dma_run(8'h04, 8'h77, 100, 0);
    dma_run(8'h05, 8'h0C, 0, 0);
    step();
    check_idle("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
